// File: rtl/requant_writeback_packer_pkg.sv
// rtl/requant_writeback_packer_pkg.sv - shared widths, lane math and FSM encoding for the writeback packer
package requant_writeback_packer_pkg;

  localparam int WB_DATA_WIDTH  = 8;
  localparam int WB_SRAM_WIDTH  = 64;
  localparam int WB_ADDR_WIDTH  = 13;
  localparam int WB_COUNT_WIDTH = 18;
  localparam int WB_BPW         = WB_SRAM_WIDTH / WB_DATA_WIDTH;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_PACK  = 2'd1,
    WB_FLUSH = 2'd2,
    WB_DONE  = 2'd3
  } wb_state_e;

  function automatic int wb_lane_bits(input int bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

endpackage

// File: rtl/requant_writeback_packer_strobe_gen.sv
// rtl/requant_writeback_packer_strobe_gen.sv - byte-lane enables for lanes 0..last_lane_i
module requant_writeback_packer_strobe_gen #(
  parameter int BPW    = 8,
  parameter int LANE_W = 3
) (
  input  logic [LANE_W-1:0] last_lane_i,
  output logic [BPW-1:0]    strb_o
);

  always_comb begin
    strb_o = '0;
    for (int i = 0; i < BPW; i++) begin
      strb_o[i] = (i <= int'(last_lane_i));
    end
  end

endmodule

// File: rtl/requant_writeback_packer.sv
// rtl/requant_writeback_packer.sv - packs serial int8 requant results into strobed SRAM word writes
module requant_writeback_packer
  import requant_writeback_packer_pkg::*;
#(
  parameter int DATA_WIDTH  = WB_DATA_WIDTH,
  parameter int SRAM_WIDTH  = WB_SRAM_WIDTH,
  parameter int ADDR_WIDTH  = WB_ADDR_WIDTH,
  parameter int COUNT_WIDTH = WB_COUNT_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic [ADDR_WIDTH-1:0]            base_addr_i,
  input  logic [COUNT_WIDTH-1:0]           total_count_i,
  input  logic                             in_valid_i,
  input  logic [DATA_WIDTH-1:0]            in_data_i,
  output logic                             in_ready_o,
  output logic                             sram_we_o,
  output logic [ADDR_WIDTH-1:0]            sram_addr_o,
  output logic [SRAM_WIDTH-1:0]            sram_wdata_o,
  output logic [SRAM_WIDTH/DATA_WIDTH-1:0] sram_wstrb_o,
  input  logic                             sram_ready_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [COUNT_WIDTH-1:0]           elem_idx_o
);

  localparam int BPW    = SRAM_WIDTH / DATA_WIDTH;
  localparam int LANE_W = wb_lane_bits(BPW);

  wb_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [COUNT_WIDTH-1:0] total_q;
  logic [COUNT_WIDTH-1:0] elem_idx_q;
  logic [ADDR_WIDTH-1:0]  word_idx_q;
  logic [LANE_W-1:0]      lane_q;
  logic [SRAM_WIDTH-1:0]  pack_buf_q;
  logic                   out_valid_q;
  logic [ADDR_WIDTH-1:0]  out_addr_q;
  logic [SRAM_WIDTH-1:0]  out_data_q;
  logic [BPW-1:0]         out_strb_q;

  logic                   last_elem;
  logic                   word_done;
  logic                   in_hs;
  logic                   start_ok;
  logic [SRAM_WIDTH-1:0]  word_d;
  logic [BPW-1:0]         strb_d;

  assign last_elem = (elem_idx_q == total_q - COUNT_WIDTH'(1));
  assign word_done = (lane_q == LANE_W'(BPW - 1)) || last_elem;
  assign in_hs     = in_valid_i && in_ready_o;
  assign start_ok  = (state_q == WB_IDLE) && start_i;

  always_comb begin
    word_d = pack_buf_q;
    word_d[int'(lane_q)*DATA_WIDTH +: DATA_WIDTH] = in_data_i;
  end

  requant_writeback_packer_strobe_gen #(
    .BPW    (BPW),
    .LANE_W (LANE_W)
  ) u_strobe_gen (
    .last_lane_i (lane_q),
    .strb_o      (strb_d)
  );

  // A completing element may only enter when the output register can take the word this cycle.
  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (start_i) begin
          state_d = (total_count_i == '0) ? WB_DONE : WB_PACK;
        end
      end
      WB_PACK: begin
        in_ready_o = !(word_done && out_valid_q && !sram_ready_i);
        if (in_valid_i && in_ready_o && last_elem) begin
          state_d = WB_FLUSH;
        end
      end
      WB_FLUSH: begin
        if (!out_valid_q) begin
          state_d = WB_DONE;
        end
      end
      WB_DONE: state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WB_IDLE;
      base_q      <= '0;
      total_q     <= '0;
      elem_idx_q  <= '0;
      word_idx_q  <= '0;
      lane_q      <= '0;
      pack_buf_q  <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        base_q     <= base_addr_i;
        total_q    <= total_count_i;
        elem_idx_q <= '0;
        word_idx_q <= '0;
        lane_q     <= '0;
        pack_buf_q <= '0;
      end
      if (in_hs) begin
        elem_idx_q <= elem_idx_q + COUNT_WIDTH'(1);
        if (word_done) begin
          lane_q     <= '0;
          pack_buf_q <= '0;
          word_idx_q <= word_idx_q + ADDR_WIDTH'(1);
        end else begin
          lane_q     <= lane_q + LANE_W'(1);
          pack_buf_q <= word_d;
        end
      end
      // word_idx_q counts words handed to the output register, so it already names the next address.
      if (in_hs && word_done) begin
        out_valid_q <= 1'b1;
        out_addr_q  <= base_q + word_idx_q;
        out_data_q  <= word_d;
        out_strb_q  <= strb_d;
      end else if (out_valid_q && sram_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign sram_we_o    = out_valid_q;
  assign sram_addr_o  = out_addr_q;
  assign sram_wdata_o = out_data_q;
  assign sram_wstrb_o = out_strb_q;
  assign busy_o       = (state_q != WB_IDLE);
  assign done_o       = (state_q == WB_DONE);
  assign elem_idx_o   = elem_idx_q;

endmodule

// File: tb/tb_requant_writeback_packer.sv
// tb/tb_requant_writeback_packer.sv - directed bench with a word-level scoreboard model
module tb_requant_writeback_packer;

  localparam int DW = 8, SW = 64, AW = 13, CW = 18, BPW = SW / DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [CW-1:0] total_count_i = '0;
  logic          in_valid_i = 1'b0;
  logic [DW-1:0] in_data_i = '0;
  logic          in_ready_o;
  logic          sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [SW-1:0] sram_wdata_o;
  logic [BPW-1:0] sram_wstrb_o;
  logic          sram_ready_i = 1'b1;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] elem_idx_o;

  requant_writeback_packer dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .total_count_i (total_count_i),
    .in_valid_i    (in_valid_i),
    .in_data_i     (in_data_i),
    .in_ready_o    (in_ready_o),
    .sram_we_o     (sram_we_o),
    .sram_addr_o   (sram_addr_o),
    .sram_wdata_o  (sram_wdata_o),
    .sram_wstrb_o  (sram_wstrb_o),
    .sram_ready_i  (sram_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .elem_idx_o    (elem_idx_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [SW-1:0]  data;
    logic [BPW-1:0] strb;
  } wr_t;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] job_data[$];
  wr_t        exp_q[$];
  wr_t        got_q[$];
  int         acc_count = 0;
  int         mon_count = 0;
  logic [AW-1:0] mon_base = '0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         start_cyc = 0;
  int         last_write_cyc = 0;
  int         ready_drop_idx = -1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, got, exp);
  endtask

  // Model: at the accepted start, split the job's element list into words.
  bit            lat_flag = 0;
  logic [AW-1:0] lat_addr = '0;
  bit            stall_prev = 0;
  wr_t           stall_w;

  always @(negedge clk) begin
    wr_t e, g;
    if (rst) begin
      lat_flag   = 0;
      stall_prev = 0;
      exp_q.delete();
    end else begin
      if (lat_flag) begin
        check("latency_we", sram_we_o, 1);
        check("latency_addr", sram_addr_o, lat_addr);
        lat_flag = 0;
      end
      if (stall_prev) begin
        check("stall_we", sram_we_o, 1);
        check("stall_addr", sram_addr_o, stall_w.addr);
        check("stall_wdata", sram_wdata_o, stall_w.data);
        check("stall_wstrb", sram_wstrb_o, stall_w.strb);
      end
      if (sram_we_o && sram_ready_i) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got write at addr %h, required no write", sram_addr_o);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", sram_addr_o, e.addr);
          check("write_wdata", sram_wdata_o, e.data);
          check("write_wstrb", sram_wstrb_o, e.strb);
        end
        g.addr = sram_addr_o; g.data = sram_wdata_o; g.strb = sram_wstrb_o;
        got_q.push_back(g);
        last_write_cyc = cyc;
      end
      stall_prev = sram_we_o && !sram_ready_i;
      stall_w.addr = sram_addr_o; stall_w.data = sram_wdata_o; stall_w.strb = sram_wstrb_o;
      if (in_valid_i && in_ready_o) begin
        check("elem_idx", elem_idx_o, acc_count);
        if ((acc_count % BPW == BPW - 1) || (acc_count == mon_count - 1)) begin
          lat_flag = 1;
          lat_addr = AW'(int'(mon_base) + acc_count / BPW);
        end
        acc_count++;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (start_i && !busy_o) begin
        mon_base  = base_addr_i;
        mon_count = int'(total_count_i);
        acc_count = 0;
        done_cnt  = 0;
        start_cyc = cyc;
        lat_flag  = 0;
        exp_q.delete();
        for (int w = 0; w < (mon_count + BPW - 1) / BPW; w++) begin
          e.addr = AW'(int'(mon_base) + w);
          e.data = '0;
          e.strb = '0;
          for (int l = 0; l < BPW; l++) begin
            if (w * BPW + l < mon_count) begin
              e.data[l*DW +: DW] = job_data[w * BPW + l];
              e.strb[l] = 1'b1;
            end
          end
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [AW-1:0] b, input int n);
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = b; total_count_i = CW'(n);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic stream(input int n_send, input int stall_cycles);
    int i = 0;
    int t = 0;
    ready_drop_idx = -1;
    while (i < n_send && t < 400) begin
      in_valid_i   = 1'b1;
      in_data_i    = job_data[i];
      sram_ready_i = (t >= stall_cycles);
      @(negedge clk);
      if (in_ready_o) i++;
      else if (ready_drop_idx < 0) ready_drop_idx = i;
      @(posedge clk); #1;
      t++;
    end
    in_valid_i   = 1'b0;
    sram_ready_i = 1'b1;
    check("stream_sent", i, n_send);
  endtask

  task automatic load_data(input int n, input int first);
    job_data.delete();
    for (int k = 0; k < n; k++) job_data.push_back(8'(first + k));
  endtask

  int g0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and IDLE ignores in_valid.
    @(negedge clk);
    check("rst_we", sram_we_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    in_valid_i = 1'b1; in_data_i = 8'h55;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", in_ready_o, 0);
    end
    check("idle_elem_idx", elem_idx_o, 0);
    @(posedge clk); #1 in_valid_i = 1'b0;

    // Full words, no stall.
    load_data(16, 0);
    g0 = got_q.size();
    start_job(13'h010, 16);
    stream(16, 0);
    settle(8);
    check("full_nwrites", got_q.size() - g0, 2);
    check("full_addr0", got_q[g0].addr, 13'h010);
    check("full_wdata0", got_q[g0].data, 64'h0706050403020100);
    check("full_wstrb0", got_q[g0].strb, 8'hFF);
    check("full_addr1", got_q[g0+1].addr, 13'h011);
    check("full_wdata1", got_q[g0+1].data, 64'h0F0E0D0C0B0A0908);
    check("full_no_stall", ready_drop_idx, -1);
    check("full_done_cnt", done_cnt, 1);
    check("full_done_delay", done_cyc - last_write_cyc, 2);
    check("full_busy_after", busy_o, 0);

    // Partial tail word.
    load_data(11, 8'h80);
    g0 = got_q.size();
    start_job(13'h030, 11);
    stream(11, 0);
    settle(8);
    check("tail_nwrites", got_q.size() - g0, 2);
    check("tail_addr1", got_q[g0+1].addr, 13'h031);
    check("tail_wdata1", got_q[g0+1].data, 64'h00000000008A8988);
    check("tail_wstrb1", got_q[g0+1].strb, 8'h07);
    check("tail_done_cnt", done_cnt, 1);

    // Backpressure: SRAM stalls for 20 cycles while data streams.
    load_data(16, 8'h30);
    g0 = got_q.size();
    start_job(13'h020, 16);
    stream(16, 20);
    settle(8);
    check("bp_drop_idx", ready_drop_idx, 15);
    check("bp_nwrites", got_q.size() - g0, 2);
    check("bp_wdata0", got_q[g0].data, 64'h3736353433323130);
    check("bp_wdata1", got_q[g0+1].data, 64'h3F3E3D3C3B3A3938);
    check("bp_accepted", acc_count, 16);
    check("bp_done_cnt", done_cnt, 1);

    // Zero count.
    g0 = got_q.size();
    start_job(13'h050, 0);
    settle(4);
    check("zero_done_cnt", done_cnt, 1);
    check("zero_done_latency", (done_cyc - start_cyc) <= 2, 1);
    check("zero_nwrites", got_q.size() - g0, 0);

    // Reset mid-job, then a fresh one-word job.
    load_data(16, 0);
    g0 = got_q.size();
    start_job(13'h040, 16);
    stream(5, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_we", sram_we_o, 0);
    check("mid_rst_addr", sram_addr_o, 0);
    check("mid_rst_wdata", sram_wdata_o, 0);
    check("mid_rst_wstrb", sram_wstrb_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_done", done_o, 0);
    check("mid_rst_elem_idx", elem_idx_o, 0);
    check("mid_rst_in_ready", in_ready_o, 0);
    load_data(8, 8'hA0);
    start_job(13'h123, 8);
    stream(8, 0);
    settle(8);
    check("post_rst_nwrites", got_q.size() - g0, 1);
    check("post_rst_addr", got_q[g0].addr, 13'h123);
    check("post_rst_wdata", got_q[g0].data, 64'hA7A6A5A4A3A2A1A0);
    check("post_rst_wstrb", got_q[g0].strb, 8'hFF);

    // Address wrap.
    load_data(16, 8'h10);
    g0 = got_q.size();
    start_job(13'h1FFF, 16);
    stream(16, 0);
    settle(8);
    check("wrap_nwrites", got_q.size() - g0, 2);
    check("wrap_addr0", got_q[g0].addr, 13'h1FFF);
    check("wrap_addr1", got_q[g0+1].addr, 13'h0000);

    check("final_exp_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
